// File: rtl/meduram_pkg.sv
// meduram_pkg: shared types and helpers for the banked multi-port RAM
// live value table.
//   lvt_state_t     : sweep FSM states (INIT = clearing table, IDLE = usable)
//   COLLISION_CNT_W : width of the optional write-collision counter
//   clog2_min1()    : ceil(log2(n)), never less than 1 (safe vector width)
package meduram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } lvt_state_t;

    localparam int unsigned COLLISION_CNT_W = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lvt_write_arbiter.sv
// lvt_write_arbiter: combinational per-row write resolution for the live
// value table. For every tracked row it reports whether any write agent
// targets it and which agent owns it (highest agent index wins). Addresses
// at or above RAM_DEPTH match no row and are therefore ignored.
// Optional feature macro: MEDURAM_COLLISION_CNT_EN (adds o_collision).
// Ports:
//   i_wren        in   NB_WRAGENT               per-agent write strobe
//   i_wraddr      in   NB_WRAGENT*ADDR_WIDTH    per-agent write row
//   o_row_we      out  RAM_DEPTH                row is written this cycle
//   o_row_owner   out  RAM_DEPTH*SELECT_WIDTH   winning agent per row
//   o_collision   out  1                        >= 2 agents hit one row (macro only)
module lvt_write_arbiter
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned RAM_DEPTH    = 2**ADDR_WIDTH,
    parameter int unsigned NB_WRAGENT   = 2,
    parameter int unsigned SELECT_WIDTH = clog2_min1(NB_WRAGENT)
) (
    input  logic [NB_WRAGENT-1:0]             i_wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]  i_wraddr,
    output logic [RAM_DEPTH-1:0]              o_row_we,
    output logic [RAM_DEPTH*SELECT_WIDTH-1:0] o_row_owner
`ifdef MEDURAM_COLLISION_CNT_EN
    ,
    output logic                              o_collision
`endif
);

    always_comb begin
        o_row_we    = '0;
        o_row_owner = '0;
`ifdef MEDURAM_COLLISION_CNT_EN
        o_collision = 1'b0;
`endif
        for (int unsigned r = 0; r < RAM_DEPTH; r++) begin
            // Ascending agent order: a later (higher) agent overwrites the owner.
            for (int unsigned a = 0; a < NB_WRAGENT; a++) begin
                if (i_wren[a] && (i_wraddr[a*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
`ifdef MEDURAM_COLLISION_CNT_EN
                    if (o_row_we[r]) begin
                        o_collision = 1'b1;
                    end
`endif
                    o_row_we[r] = 1'b1;
                    o_row_owner[r*SELECT_WIDTH +: SELECT_WIDTH] = SELECT_WIDTH'(a);
                end
            end
        end
    end

endmodule

// File: rtl/live_value_table.sv
// live_value_table: multi-read-port owner table for the banked multi-port
// RAM. Remembers which write agent last wrote each row and answers up to
// NB_RDAGENT lookups per cycle with a registered bank select and hit flag.
// Table storage is not reset; a sweep FSM clears it after reset and flush.
// Optional feature macro: MEDURAM_COLLISION_CNT_EN (adds wr_collision and
// collision_count).
// Ports:
//   aclk            in   1                        clock
//   aresetn         in   1                        async active-low reset
//   flush           in   1                        pulse: clear table (restart sweep)
//   ready           out  1                        1 = usable, 0 = sweeping
//   wren/wraddr     in   NB_WRAGENT(*ADDR_WIDTH)  per-agent write strobe/row
//   rden/rdaddr     in   NB_RDAGENT(*ADDR_WIDTH)  per-agent lookup strobe/row
//   rd_valid        out  NB_RDAGENT               registered rden
//   rd_hit          out  NB_RDAGENT               row written since last clear
//   bank_select     out  NB_RDAGENT*SELECT_WIDTH  owning write agent
//   wr_collision    out  1                        collision in prior cycle (macro only)
//   collision_count out  16                       saturating count (macro only)
module live_value_table
    import meduram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned RAM_DEPTH    = 2**ADDR_WIDTH,
    parameter int unsigned NB_WRAGENT   = 2,
    parameter int unsigned NB_RDAGENT   = 2,
    parameter int unsigned SELECT_WIDTH = clog2_min1(NB_WRAGENT)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             flush,
    output logic                             ready,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_RDAGENT-1:0]            rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RDAGENT-1:0]            rd_valid,
    output logic [NB_RDAGENT-1:0]            rd_hit,
    output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select
`ifdef MEDURAM_COLLISION_CNT_EN
    ,
    output logic                             wr_collision,
    output logic [COLLISION_CNT_W-1:0]       collision_count
`endif
);

    localparam int unsigned PTR_W   = clog2_min1(RAM_DEPTH);
    localparam int unsigned ENTRY_W = SELECT_WIDTH + 1;

    lvt_state_t                         r_state;
    logic [PTR_W-1:0]                   r_ptr;
    logic                               r_ready;
    logic [ENTRY_W-1:0]                 r_table [RAM_DEPTH];
    logic [NB_RDAGENT-1:0]              r_rd_valid;
    logic [NB_RDAGENT-1:0]              r_rd_hit;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] r_bank_select;

    logic                               w_idle;
    logic [RAM_DEPTH-1:0]               w_row_we;
    logic [RAM_DEPTH*SELECT_WIDTH-1:0]  w_row_owner;
    logic [NB_RDAGENT-1:0]              w_lk_hit;
    logic [NB_RDAGENT*SELECT_WIDTH-1:0] w_lk_sel;
`ifdef MEDURAM_COLLISION_CNT_EN
    logic                               w_collision;
    logic                               r_wr_collision;
    logic [COLLISION_CNT_W-1:0]         r_collision_count;
`endif

    assign w_idle = (r_state == IDLE);

    lvt_write_arbiter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RAM_DEPTH    (RAM_DEPTH),
        .NB_WRAGENT   (NB_WRAGENT),
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_arbiter (
        .i_wren      (wren),
        .i_wraddr    (wraddr),
        .o_row_we    (w_row_we),
        .o_row_owner (w_row_owner)
`ifdef MEDURAM_COLLISION_CNT_EN
        ,
        .o_collision (w_collision)
`endif
    );

    // Sweep FSM: INIT clears one row per cycle; flush restarts from row 0.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else if (flush) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
        end else begin
            unique case (r_state)
                INIT: begin
                    if (r_ptr == PTR_W'(RAM_DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= INIT;
                    r_ptr   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Table storage: no reset so it can map to distributed RAM.
    always_ff @(posedge aclk) begin
        for (int unsigned r = 0; r < RAM_DEPTH; r++) begin
            if (!w_idle) begin
                if (r_ptr == PTR_W'(r)) begin
                    r_table[r] <= '0;
                end
            end else if (w_row_we[r]) begin
                r_table[r] <= {1'b1, w_row_owner[r*SELECT_WIDTH +: SELECT_WIDTH]};
            end
        end
    end

    // Lookup with write-first bypass; out-of-range rows match nothing and
    // the sweep forces a miss.
    always_comb begin
        w_lk_hit = '0;
        w_lk_sel = '0;
        if (w_idle) begin
            for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
                for (int unsigned r = 0; r < RAM_DEPTH; r++) begin
                    if (rdaddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                        if (w_row_we[r]) begin
                            w_lk_hit[i] = 1'b1;
                            w_lk_sel[i*SELECT_WIDTH +: SELECT_WIDTH] =
                                w_row_owner[r*SELECT_WIDTH +: SELECT_WIDTH];
                        end else begin
                            w_lk_hit[i] = r_table[r][SELECT_WIDTH];
                            w_lk_sel[i*SELECT_WIDTH +: SELECT_WIDTH] =
                                r_table[r][SELECT_WIDTH-1:0];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_valid    <= '0;
            r_rd_hit      <= '0;
            r_bank_select <= '0;
        end else begin
            r_rd_valid <= rden;
            for (int unsigned i = 0; i < NB_RDAGENT; i++) begin
                if (rden[i]) begin
                    r_rd_hit[i] <= w_lk_hit[i];
                    r_bank_select[i*SELECT_WIDTH +: SELECT_WIDTH] <=
                        w_lk_sel[i*SELECT_WIDTH +: SELECT_WIDTH];
                end
            end
        end
    end

    assign ready       = r_ready;
    assign rd_valid    = r_rd_valid;
    assign rd_hit      = r_rd_hit;
    assign bank_select = r_bank_select;

`ifdef MEDURAM_COLLISION_CNT_EN
    // Only writes that actually land (IDLE) count as collisions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_collision    <= 1'b0;
            r_collision_count <= '0;
        end else begin
            r_wr_collision <= w_idle & w_collision;
            if (flush) begin
                r_collision_count <= '0;
            end else if (w_idle && w_collision && (r_collision_count != '1)) begin
                r_collision_count <= r_collision_count + 1'b1;
            end
        end
    end

    assign wr_collision    = r_wr_collision;
    assign collision_count = r_collision_count;
`endif

endmodule
